// File: rtl/led_pattern_engine.sv
// LED pattern engine: FLASH/SHIFT/BOUNCE patterns over NB_LEDS LEDs and N_COLORS channels, with speed, direction and colour select.
// Latency: button press acts on the state one clock after its rising edge, and outputs are registered one clock behind the state.
// Backpressure: none. Inputs are sampled every cycle. Optional PWM dimming is enabled by defining LED_PWM_DIM_EN.
module led_pattern_engine #(
    parameter int NB_LEDS    = 4,
    parameter int N_COLORS   = 3,
    parameter int NB_COUNTER = 16,
    parameter int NB_SPEED   = 2,
    parameter int BASE_LIMIT = 4096,
    parameter int NB_PWM     = 8
) (
    input  logic                         clock,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic [NB_SPEED-1:0]          i_speed,
    input  logic                         i_dir,
    input  logic                         i_mode_btn,
    input  logic [N_COLORS-1:0]          i_color_btn,
`ifdef LED_PWM_DIM_EN
    input  logic [NB_PWM-1:0]            i_dim,
`endif
    output logic [NB_LEDS-1:0]           o_led,
    output logic [N_COLORS*NB_LEDS-1:0]  o_led_rgb,
    output logic                         o_tick
);

    typedef enum logic [1:0] {
        MODE_FLASH  = 2'd0,
        MODE_SHIFT  = 2'd1,
        MODE_BOUNCE = 2'd2
    } mode_t;

    logic                  mode_btn_q;
    logic [N_COLORS-1:0]   color_btn_q;
    logic                  mode_press;
    logic [N_COLORS-1:0]   color_press;
    logic [N_COLORS-1:0]   color_pick;
    logic [NB_COUNTER-1:0] count_q;
    logic [NB_COUNTER-1:0] limit;
    logic                  tick;
    mode_t                 mode_q, mode_d;
    logic [NB_LEDS-1:0]    pattern_q, pattern_d;
    logic                  bounce_up_q, bounce_up_d;
    logic [N_COLORS-1:0]   color_q, color_d;
    logic                  tick_q;
    logic                  led_on;

    // Button history for rising-edge detection; a held button presses only once.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            mode_btn_q  <= 1'b0;
            color_btn_q <= '0;
        end else begin
            mode_btn_q  <= i_mode_btn;
            color_btn_q <= i_color_btn;
        end
    end

    // Edge detect, lowest-index colour isolation and tick compare.
    always_comb begin
        mode_press  = i_mode_btn & ~mode_btn_q;
        color_press = i_color_btn & ~color_btn_q;
        color_pick  = color_press & (~color_press + N_COLORS'(1));
        limit       = NB_COUNTER'(BASE_LIMIT) << i_speed;
        // >= rather than == so a speed reduction mid-count ticks immediately.
        tick        = i_enable && (count_q >= (limit - NB_COUNTER'(1)));
    end

    // Prescaler: cleared on mode change, while disabled, and on wrap.
    always_ff @(posedge clock) begin
        if (i_reset)
            count_q <= '0;
        else if (mode_press || !i_enable || tick)
            count_q <= '0;
        else
            count_q <= count_q + NB_COUNTER'(1);
    end

    // Mode sequencing and pattern update; a mode press overrides a coincident tick.
    always_comb begin
        mode_d      = mode_q;
        pattern_d   = pattern_q;
        bounce_up_d = bounce_up_q;
        if (mode_press) begin
            case (mode_q)
                MODE_FLASH: begin
                    mode_d    = MODE_SHIFT;
                    pattern_d = NB_LEDS'(1);
                end
                MODE_SHIFT: begin
                    mode_d      = MODE_BOUNCE;
                    pattern_d   = NB_LEDS'(1);
                    bounce_up_d = 1'b1;
                end
                default: begin
                    mode_d    = MODE_FLASH;
                    pattern_d = '0;
                end
            endcase
        end else if (tick) begin
            case (mode_q)
                MODE_FLASH: pattern_d = ~pattern_q;
                MODE_SHIFT: begin
                    if (i_dir)
                        pattern_d = (pattern_q >> 1) | (pattern_q << (NB_LEDS - 1));
                    else
                        pattern_d = (pattern_q << 1) | (pattern_q >> (NB_LEDS - 1));
                end
                MODE_BOUNCE: begin
                    if (NB_LEDS == 1) begin
                        pattern_d = NB_LEDS'(1);
                    end else if (bounce_up_q) begin
                        // Turn around at the MSB without repeating it.
                        if (pattern_q[NB_LEDS-1]) begin
                            pattern_d   = pattern_q >> 1;
                            bounce_up_d = 1'b0;
                        end else begin
                            pattern_d = pattern_q << 1;
                        end
                    end else begin
                        if (pattern_q[0]) begin
                            pattern_d   = pattern_q << 1;
                            bounce_up_d = 1'b1;
                        end else begin
                            pattern_d = pattern_q >> 1;
                        end
                    end
                end
                default: pattern_d = '0;
            endcase
        end
    end

    // Colour selection: a press loads the lowest pressed index, otherwise hold.
    always_comb begin
        color_d = color_q;
        if (|color_press)
            color_d = color_pick;
    end

    // State registers; tick_q delays the step so o_tick lines up with o_led.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            mode_q      <= MODE_FLASH;
            pattern_q   <= '0;
            bounce_up_q <= 1'b1;
            color_q     <= N_COLORS'(1);
            tick_q      <= 1'b0;
        end else begin
            mode_q      <= mode_d;
            pattern_q   <= pattern_d;
            bounce_up_q <= bounce_up_d;
            color_q     <= color_d;
            tick_q      <= tick && !mode_press;
        end
    end

`ifdef LED_PWM_DIM_EN
    logic [NB_PWM-1:0] pwm_cnt_q;

    // Free-running dimming counter.
    always_ff @(posedge clock) begin
        if (i_reset)
            pwm_cnt_q <= '0;
        else
            pwm_cnt_q <= pwm_cnt_q + NB_PWM'(1);
    end

    // LEDs are lit for i_dim out of every 2**NB_PWM clocks.
    always_comb begin
        led_on = (pwm_cnt_q < i_dim);
    end
`else
    // Without dimming the pattern drives the pins directly.
    always_comb begin
        led_on = 1'b1;
    end
`endif

    // Registered outputs: mono pattern, per-colour slices and the step pulse.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            o_led     <= '0;
            o_led_rgb <= '0;
            o_tick    <= 1'b0;
        end else begin
            o_led  <= pattern_q & {NB_LEDS{led_on}};
            o_tick <= tick_q;
            for (int c = 0; c < N_COLORS; c++)
                o_led_rgb[c*NB_LEDS +: NB_LEDS] <= color_q[c] ? (pattern_q & {NB_LEDS{led_on}}) : '0;
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// Directed bench for led_pattern_engine with a 4-clock base tick period.
// Latency: every check samples 1 time unit after a rising clock edge.
// Backpressure: none; stimulus is driven in lock-step with the clock.
module tb_led_pattern_engine;

    logic        clock;
    logic        i_reset;
    logic        i_enable;
    logic [1:0]  i_speed;
    logic        i_dir;
    logic        i_mode_btn;
    logic [2:0]  i_color_btn;
`ifdef LED_PWM_DIM_EN
    logic [7:0]  i_dim;
`endif
    logic [3:0]  o_led;
    logic [11:0] o_led_rgb;
    logic        o_tick;

    int total;
    int bad;

    led_pattern_engine #(
        .NB_LEDS(4), .N_COLORS(3), .NB_COUNTER(16), .NB_SPEED(2), .BASE_LIMIT(4), .NB_PWM(8)
    ) dut (
        .clock(clock),
        .i_reset(i_reset),
        .i_enable(i_enable),
        .i_speed(i_speed),
        .i_dir(i_dir),
        .i_mode_btn(i_mode_btn),
        .i_color_btn(i_color_btn),
`ifdef LED_PWM_DIM_EN
        .i_dim(i_dim),
`endif
        .o_led(o_led),
        .o_led_rgb(o_led_rgb),
        .o_tick(o_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Advance until o_tick is seen (bounded); returns cycles taken.
    task automatic wait_tick(input string tag, output int n);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!o_tick && n < 100);
        chk(tag, {31'b0, o_tick}, 32'd1);
    endtask

    logic [3:0] bounce_seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic [3:0] shift_seq  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int n;
        logic seen;
        total = 0;
        bad   = 0;
        i_reset = 1'b1; i_enable = 1'b0; i_speed = 2'd0; i_dir = 1'b0;
        i_mode_btn = 1'b0; i_color_btn = 3'b000;
`ifdef LED_PWM_DIM_EN
        i_dim = 8'hFF;
`endif
        step(2);
        chk("rst_led", {28'b0, o_led}, 32'h0);
        chk("rst_rgb", {20'b0, o_led_rgb}, 32'h0);
        chk("rst_tick", {31'b0, o_tick}, 32'h0);

        // 1: FLASH toggling every 4 clocks, red only.
        i_reset = 1'b0; i_enable = 1'b1;
        wait_tick("t1_tick0", n);
        chk("t1_first_lat", n, 5);
        chk("t1_led_on", {28'b0, o_led}, 32'hF);
        chk("t1_rgb_red", {20'b0, o_led_rgb}, 32'h00F);
        step(1);
        chk("t1_tick_gap", {31'b0, o_tick}, 32'h0);
        step(3);
        chk("t1_tick_period", {31'b0, o_tick}, 32'h1);
        chk("t1_led_off", {28'b0, o_led}, 32'h0);
        step(4);
        chk("t1_led_on2", {28'b0, o_led}, 32'hF);

        // 2: SHIFT toward MSB, then toward LSB.
        i_mode_btn = 1'b1;
        step(2);
        chk("t2_entry", {28'b0, o_led}, 32'h1);
        i_mode_btn = 1'b0;
        wait_tick("t2_tick", n);
        chk("t2_s0", {28'b0, o_led}, {28'b0, shift_seq[0]});
        for (int i = 1; i < 4; i++) begin
            step(4);
            chk("t2_shift_tick", {31'b0, o_tick}, 32'h1);
            chk("t2_shift", {28'b0, o_led}, {28'b0, shift_seq[i]});
        end
        i_dir = 1'b1;
        step(4);
        chk("t2_dir1_wrap", {28'b0, o_led}, 32'h8);
        step(4);
        chk("t2_dir1_next", {28'b0, o_led}, 32'h4);

        // 3: two presses from FLASH reach BOUNCE; i_dir left at 1 is ignored.
        i_reset = 1'b1;
        step(1);
        i_reset = 1'b0; i_mode_btn = 1'b1;
        step(1);
        i_mode_btn = 1'b0;
        step(1);
        i_mode_btn = 1'b1;
        step(1);
        i_mode_btn = 1'b0;
        step(1);
        chk("t3_entry", {28'b0, o_led}, 32'h1);
        wait_tick("t3_tick", n);
        chk("t3_b0", {28'b0, o_led}, {28'b0, bounce_seq[0]});
        for (int i = 1; i < 7; i++) begin
            step(4);
            chk("t3_bounce", {28'b0, o_led}, {28'b0, bounce_seq[i]});
        end

        // 4: speed 3, mid-count speed drop, then freeze.
        i_speed = 2'd3;
        wait_tick("t4_tick_s3", n);
        chk("t4_period_s3a", n, 32);
        chk("t4_led_a", {28'b0, o_led}, 32'h4);
        wait_tick("t4_tick_s3b", n);
        chk("t4_period_s3b", n, 32);
        chk("t4_led_b", {28'b0, o_led}, 32'h8);
        step(19);
        i_speed = 2'd0;
        step(1);
        chk("t4_drop_gap", {31'b0, o_tick}, 32'h0);
        step(1);
        chk("t4_drop_tick", {31'b0, o_tick}, 32'h1);
        chk("t4_led_c", {28'b0, o_led}, 32'h4);
        step(4);
        chk("t4_s0_tick", {31'b0, o_tick}, 32'h1);
        chk("t4_led_d", {28'b0, o_led}, 32'h2);
        i_enable = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            seen = seen | o_tick;
        end
        chk("t4_frozen_tick", {31'b0, seen}, 32'h0);
        chk("t4_frozen_led", {28'b0, o_led}, 32'h2);

        // 5: colour selection with held buttons, then mode press on a tick.
        i_color_btn = 3'b110;
        step(2);
        chk("t5_green", {20'b0, o_led_rgb}, 32'h020);
        step(8);
        chk("t5_green_held", {20'b0, o_led_rgb}, 32'h020);
        i_color_btn = 3'b111;
        step(2);
        chk("t5_red", {20'b0, o_led_rgb}, 32'h002);
        step(8);
        chk("t5_no_retrigger", {20'b0, o_led_rgb}, 32'h002);
        i_color_btn = 3'b000;
        step(1);
        i_color_btn = 3'b100;
        step(2);
        chk("t5_blue", {20'b0, o_led_rgb}, 32'h200);
        i_color_btn = 3'b000;
        i_mode_btn = 1'b1;
        step(1);
        i_mode_btn = 1'b0;
        step(1);
        chk("t5_flash_zero", {28'b0, o_led}, 32'h0);
        i_dir = 1'b0; i_enable = 1'b1;
        step(3);
        i_mode_btn = 1'b1;
        step(1);
        step(1);
        chk("t5_coinc_led", {28'b0, o_led}, 32'h1);
        chk("t5_coinc_tick", {31'b0, o_tick}, 32'h0);
        chk("t5_coinc_rgb", {20'b0, o_led_rgb}, 32'h100);
        step(1);
        chk("t5_coinc_tick2", {31'b0, o_tick}, 32'h0);
        i_mode_btn = 1'b0;
        wait_tick("t5_tick", n);
        chk("t5_after", {28'b0, o_led}, 32'h2);
        chk("t5_after_rgb", {20'b0, o_led_rgb}, 32'h200);

        // 6: reset during BOUNCE overrides coincident presses.
        i_mode_btn = 1'b1;
        step(1);
        i_mode_btn = 1'b0;
        wait_tick("t6_tick", n);
        chk("t6_bounce", {28'b0, o_led}, 32'h2);
        i_reset = 1'b1; i_mode_btn = 1'b1; i_color_btn = 3'b010;
        step(1);
        chk("t6_rst_led", {28'b0, o_led}, 32'h0);
        chk("t6_rst_rgb", {20'b0, o_led_rgb}, 32'h0);
        chk("t6_rst_tick", {31'b0, o_tick}, 32'h0);
        i_reset = 1'b0; i_mode_btn = 1'b0; i_color_btn = 3'b000;
        wait_tick("t6_tick2", n);
        chk("t6_lat", n, 5);
        chk("t6_flash", {28'b0, o_led}, 32'hF);
        chk("t6_red", {20'b0, o_led_rgb}, 32'h00F);

`ifdef LED_PWM_DIM_EN
        begin
            int on_cnt;
            i_enable = 1'b0;
            i_dim = 8'd64;
            step(2);
            on_cnt = 0;
            for (int i = 0; i < 256; i++) begin
                step(1);
                if (o_led[0]) on_cnt++;
            end
            chk("pwm_duty", on_cnt, 64);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
